// File: rtl/imem_uart_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// Ports: rx_valid/rx_data/rx_break (stream in), mem_we/mem_addr/mem_wdata (write out).
interface imem_uart_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    output rx_break,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  rx_break,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_uart_loader.sv
// Assembles UART bytes into LE words and writes them to imem from address 0.
// Ports: clk, rst, bus (slave), write_done, mem_full, frame_err, word_count,
// cksum (only with IMEM_LOADER_CKSUM_EN defined).
module imem_uart_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_uart_loader_if.slave    bus,
  output logic                 write_done,
  output logic                 mem_full,
  output logic                 frame_err,
  output logic [ADDR_W:0]      word_count
`ifdef IMEM_LOADER_CKSUM_EN
  ,
  output logic [31:0]          cksum
`endif
);

  typedef enum logic {
    LOAD,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [23:0] shift_q;
  logic [31:0] word;
  logic        last_addr;

  // Lane 3 comes straight from the wire so the word is ready on the 4th strobe.
  assign word = {bus.rx_data, shift_q};
  assign last_addr = (word_count[ADDR_W-1:0] == {ADDR_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD;
      idx           <= 2'd0;
      shift_q       <= 24'd0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'd0;
      word_count    <= '0;
      write_done    <= 1'b0;
      mem_full      <= 1'b0;
      frame_err     <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum         <= 32'd0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      unique case (state)
        LOAD: begin
          if (bus.rx_valid) begin
            if (bus.rx_break) begin
              idx       <= 2'd0;
              frame_err <= 1'b1;
            end else if (idx != 2'd3) begin
              shift_q[idx*8 +: 8] <= bus.rx_data;
              idx                 <= idx + 2'd1;
            end else begin
              idx <= 2'd0;
              if (word == END_WORD) begin
                state      <= DONE;
                write_done <= 1'b1;
              end else begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= word_count[ADDR_W-1:0];
                bus.mem_wdata <= word;
                word_count    <= word_count + {{ADDR_W{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CKSUM_EN
                cksum         <= cksum ^ word;
`endif
                if (last_addr) begin
                  state      <= DONE;
                  write_done <= 1'b1;
                  mem_full   <= 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench: two loaders (ADDR_W=8 and ADDR_W=2) see one byte stream.
// Ports: none; checks against a word-level reference model.
module tb_imem_uart_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_uart_loader_if #(.ADDR_W(8)) b0 ();
  imem_uart_loader_if #(.ADDR_W(2)) b1 ();

  assign b1.rx_valid = b0.rx_valid;
  assign b1.rx_data  = b0.rx_data;
  assign b1.rx_break = b0.rx_break;

  logic       done0, full0, ferr0;
  logic       done1, full1, ferr1;
  logic [8:0] wc0;
  logic [2:0] wc1;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0] ck0, ck1;
`endif

  imem_uart_loader #(.ADDR_W(8)) d0 (
    .clk(clk), .rst(rst), .bus(b0),
    .write_done(done0), .mem_full(full0),
    .frame_err(ferr0), .word_count(wc0)
`ifdef IMEM_LOADER_CKSUM_EN
    , .cksum(ck0)
`endif
  );

  imem_uart_loader #(.ADDR_W(2)) d1 (
    .clk(clk), .rst(rst), .bus(b1),
    .write_done(done1), .mem_full(full1),
    .frame_err(ferr1), .word_count(wc1)
`ifdef IMEM_LOADER_CKSUM_EN
    , .cksum(ck1)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model, one slot per DUT.
  int          m_cap  [2];
  int          m_n    [2];
  logic [31:0] m_word [2];
  int          m_wc   [2];
  bit          m_done [2];
  bit          m_full [2];
  bit          m_ferr [2];
  bit          m_we   [2];
  int          m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] m_ck   [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_word[k] = 0; m_wc[k] = 0;
      m_done[k] = 0; m_full[k] = 0; m_ferr[k] = 0;
      m_we[k] = 0; m_addr[k] = 0; m_data[k] = 0; m_ck[k] = 0;
    end
  endtask

  task automatic model_byte(input int k, input logic [7:0] d, input bit brk);
    m_we[k] = 0;
    if (m_done[k]) return;
    if (brk) begin
      m_n[k] = 0;
      m_ferr[k] = 1;
      return;
    end
    if (m_n[k] == 0) m_word[k] = 0;
    m_word[k] = m_word[k] | (32'(d) << (8 * m_n[k]));
    m_n[k]++;
    if (m_n[k] == 4) begin
      m_n[k] = 0;
      if (m_word[k] == 32'hFFFF_FFFF) begin
        m_done[k] = 1;
      end else begin
        m_we[k] = 1;
        m_addr[k] = m_wc[k];
        m_data[k] = m_word[k];
        m_wc[k]++;
        m_ck[k] ^= m_word[k];
        if (m_wc[k] == m_cap[k]) begin
          m_done[k] = 1;
          m_full[k] = 1;
        end
      end
    end
  endtask

  task automatic check(input int k);
    string p;
    p = $sformatf("d%0d.", k);
    if (k == 0) begin
      chk({p, "mem_we"}, 32'(b0.mem_we), 32'(m_we[0]));
      chk({p, "mem_addr"}, 32'(b0.mem_addr), 32'(m_addr[0]));
      chk({p, "mem_wdata"}, b0.mem_wdata, m_data[0]);
      chk({p, "word_count"}, 32'(wc0), 32'(m_wc[0]));
      chk({p, "write_done"}, 32'(done0), 32'(m_done[0]));
      chk({p, "mem_full"}, 32'(full0), 32'(m_full[0]));
      chk({p, "frame_err"}, 32'(ferr0), 32'(m_ferr[0]));
`ifdef IMEM_LOADER_CKSUM_EN
      chk({p, "cksum"}, ck0, m_ck[0]);
`endif
    end else begin
      chk({p, "mem_we"}, 32'(b1.mem_we), 32'(m_we[1]));
      chk({p, "mem_addr"}, 32'(b1.mem_addr), 32'(m_addr[1]));
      chk({p, "mem_wdata"}, b1.mem_wdata, m_data[1]);
      chk({p, "word_count"}, 32'(wc1), 32'(m_wc[1]));
      chk({p, "write_done"}, 32'(done1), 32'(m_done[1]));
      chk({p, "mem_full"}, 32'(full1), 32'(m_full[1]));
      chk({p, "frame_err"}, 32'(ferr1), 32'(m_ferr[1]));
`ifdef IMEM_LOADER_CKSUM_EN
      chk({p, "cksum"}, ck1, m_ck[1]);
`endif
    end
  endtask

  // Called at a negedge: strobe one byte across the next posedge.
  task automatic send(input logic [7:0] d, input bit brk = 1'b0);
    b0.rx_valid = 1'b1;
    b0.rx_data  = d;
    b0.rx_break = brk;
    model_byte(0, d, brk);
    model_byte(1, d, brk);
    @(posedge clk);
    @(negedge clk);
    b0.rx_valid = 1'b0;
    b0.rx_break = 1'b0;
    check(0);
    check(1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      m_we[0] = 0;
      m_we[1] = 0;
      @(posedge clk);
      @(negedge clk);
      check(0);
      check(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check(0);
    check(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    logic [31:0] w;
    m_cap[0] = 256;
    m_cap[1] = 4;
    b0.rx_valid = 1'b0;
    b0.rx_data  = 8'h00;
    b0.rx_break = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // First word lands at address 0.
    send(8'h13); send(8'h01); send(8'h01); send(8'hFC);
    chk("first_wdata", b0.mem_wdata, 32'hFC01_0113);
    idle(2);

    // Two words then terminator.
    do_reset();
    send_word(32'h0000_0013);
    send_word(32'h0211_2E23);
    send_word(32'hFFFF_FFFF);
    chk("term_done", 32'(done0), 32'd1);
    chk("term_count", 32'(wc0), 32'd2);
`ifdef IMEM_LOADER_CKSUM_EN
    chk("term_cksum", ck0, 32'h0211_2E30);
`endif
    send_word(32'h1234_5678);
    idle(2);

    // Break drops a partial word.
    do_reset();
    send(8'h55); send(8'h66); send(8'h00, 1'b1);
    send(8'h67); send(8'h80); send(8'h00); send(8'h00);
    chk("brk_wdata", b0.mem_wdata, 32'h0000_8067);
    idle(1);

    // Fill the small memory; a 5th word must not write.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      w = $urandom();
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      send_word(w);
    end
    chk("full_flag", 32'(full1), 32'd1);
    idle(1);

    // Reset in the middle of a word.
    do_reset();
    send(8'hDE); send(8'hAD); send(8'hBE);
    do_reset();
    send(8'h93); send(8'h07); send(8'h10); send(8'h00);
    chk("rst_wdata", b0.mem_wdata, 32'h0010_0793);

    // Back-to-back strobes, 5th coincident with mem_we.
    do_reset();
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("b2b_wdata", b0.mem_wdata, 32'h4433_2211);
    idle(1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 6) send(8'($urandom()), 1'b1);
      else if (r < 14) idle(1);
      else if (r < 16) send_word(32'hFFFF_FFFF);
      else send(8'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Downstream stage of the UART receiver in the boot-load path. Consumes the receiver's byte stream, assembles little-endian 32-bit instruction words (byte 0 first), and writes them to consecutive instruction-memory word addresses starting at 0. Loading ends when the terminator word arrives or memory fills. It then raises `write_done`, which releases the core from load mode.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `END_WORD`, 32'hFFFF_FFFF: terminator word that ends loading; it is never written to memory.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `rx_break` in 1: receiver detected BREAK; qualified by `rx_valid`.
- `mem_we` out 1: one-cycle instruction-memory write strobe.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: assembled word.
- `write_done` out 1: loading finished; sticky until `rst`.
- `mem_full` out 1: loading ended because the last address was written; sticky.
- `frame_err` out 1: a BREAK discarded a partial word; sticky.
- `word_count` out ADDR_W+1: number of words written to memory.
- `cksum` out 32: running XOR of written words. Only present when `IMEM_LOADER_CKSUM_EN` is defined.

## Operation
- State machine has two states: LOAD (state after reset) and DONE.
- LOAD, `rx_valid` with `rx_break`=0:
  - Store `rx_data` into byte lane `idx` of the shift buffer.
  - `idx` increments 0→1→2→3→0.
- LOAD, `rx_valid` with `rx_break`=1:
  - Discard the byte and reset `idx` to 0, dropping any partial word.
  - Set `frame_err`.
- On acceptance of the byte with `idx`=3, the assembled word is {b3,b2,b1,b0}:
  - Word == `END_WORD`: go to DONE and set `write_done`. No write occurs.
  - Otherwise: pulse `mem_we` with `mem_addr`=`word_count` and `mem_wdata`=word, then increment `word_count`.
  - If the address just written is 2^ADDR_W−1: also go to DONE and set `write_done` and `mem_full`.
- DONE: ignore all `rx_valid`. `mem_we` stays 0 and all outputs hold until `rst`.
- Collection never stalls. A byte arriving in the same cycle as `mem_we` is accepted as byte 0 of the next word.
- Reset values:
  - `mem_we`, `write_done`, `mem_full`, `frame_err` = 0.
  - `mem_addr`, `mem_wdata`, `word_count`, `idx` = 0.
  - `cksum` = 0.
  - State = LOAD.
- Reset mid-word or mid-load: everything clears immediately. The next byte is byte 0 of word 0 at address 0, overwriting earlier contents.

## Timing
- `mem_we`, `mem_addr` and `mem_wdata` are registered. With the 4th byte strobed at cycle N, `mem_we`=1 during cycle N+1 only.
- `mem_addr` and `mem_wdata` stay stable from N+1 until the next write.
- `word_count` updates at N+1, in the same edge as `mem_we` rising.
- `write_done`:
  - After a terminator: rises at N+1.
  - After the last address: rises at N+1, together with that final `mem_we`.
- `frame_err` rises the cycle after the BREAK-qualified strobe.
- No back-to-back requirement on `rx_valid`. Strobes on consecutive cycles must be handled correctly.

## Configuration
- `IMEM_LOADER_CKSUM_EN` defined:
  - `cksum` port exists.
  - `cksum` updates at N+1 as `cksum ^ mem_wdata` for each written word. The terminator is excluded.
  - Clears on `rst`.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then send bytes 13,01,01,FC → one `mem_we` pulse one cycle after the 4th strobe, `mem_addr`=0, `mem_wdata`=FC010113, `word_count`=1.
- Send words 00000013, 02112E23, then FFFFFFFF → writes at addr 0 and 1 only. `write_done`=1 the cycle after the last byte, `word_count`=2, no third `mem_we`. With CKSUM: `cksum`=02112E30.
- Send 2 bytes, a BREAK strobe, then bytes 67,80,00,00 → `frame_err`=1, single write of 00008067 at addr 0.
- `ADDR_W`=2: send 4 non-terminator words → addresses 0–3 written. `mem_full`=1 and `write_done`=1 with the 4th write. A 5th word produces no `mem_we`.
- Assert `rst` after 3 bytes of word 1, release, send 93,07,10,00 → write 00100793 at addr 0, all sticky flags 0.
- Strobe `rx_valid` on 4 consecutive cycles (AA,BB,CC,DD), then a 5th strobe coincident with `mem_we` → `mem_wdata`=DDCCBBAA, and the 5th byte is held as byte 0 of word 1.
